// File: rtl/muxd_arb.sv
// Registered N-way valid/ready merge with round-robin or fixed-priority arbitration
// and an optional forced-select mode, feeding one output register stage.
module muxd_arb #(
    parameter int N  = 3,
    parameter int W  = 16,
    parameter bit RR = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0]                 req_valid_in,
    input  logic [N-1:0][W-1:0]          req_data_in,
    output logic [N-1:0]                 req_ready_out,
    input  logic                         force_en_in,
    input  logic [$clog2(N)-1:0]         force_sel_in,
    output logic                         m_valid_out,
    output logic [W-1:0]                 m_data_out,
    output logic [$clog2(N)-1:0]         m_sel_out,
    input  logic                         m_ready_in,
    output logic [15:0]                  xfer_cnt_out
);

    localparam int SW = $clog2(N);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q;
    logic [W-1:0]    data_q;
    logic [SW-1:0]   sel_q;
    logic [SW-1:0]   ptr_q;
    logic [SW-1:0]   ptr_d;
    logic [15:0]     cnt_q;

    logic [N-1:0]    elig;
    logic [N-1:0]    grant;
    logic [SW-1:0]   gidx;
    logic            found;
    logic            space;
    logic            accept;

    // An out-of-range forced index matches no channel, so the eligible set is empty.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = req_valid_in[i] && (!force_en_in || (int'(force_sel_in) == i));
        end
    end

    always_comb begin
        logic [SW:0]   cand;
        logic [SW-1:0] idx;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        cand  = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (RR) begin
                cand = {1'b0, ptr_q} + (SW+1)'(k);
            end else begin
                cand = (SW+1)'(k);
            end
            if (cand >= (SW+1)'(N)) begin
                cand = cand - (SW+1)'(N);
            end
            idx = cand[SW-1:0];
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    always_comb begin
        space         = (state_q == EMPTY) || m_ready_in;
        req_ready_out = grant & {N{space & rst_n}};
        accept        = found && space;
        if (gidx == SW'(N - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gidx + SW'(1);
        end
    end

    // A load takes priority over a drain so back-to-back words see no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            state_q <= FULL;
            data_q  <= req_data_in[gidx];
            sel_q   <= gidx;
            cnt_q   <= cnt_q + 16'd1;
            if (RR) begin
                ptr_q <= ptr_d;
            end
        end else if (m_ready_in) begin
            state_q <= EMPTY;
        end
    end

    assign m_valid_out  = (state_q == FULL);
    assign m_data_out   = data_q;
    assign m_sel_out    = sel_q;
    assign xfer_cnt_out = cnt_q;

endmodule

// File: tb/tb_muxd_arb.sv
// Self-checking bench for muxd_arb: a round-robin and a fixed-priority instance driven
// from a vector table, a word scoreboard, and hand-written multi-cycle sequences.
module tb_muxd_arb;

    typedef struct packed {
        logic        fp;
        logic [2:0]  valid;
        logic        mready;
        logic        fen;
        logic [1:0]  fsel;
        logic [2:0]  expRdy;
        logic        expMv;
        logic [15:0] expData;
        logic [1:0]  expSel;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       vRr, vFp;
    logic [2:0][15:0] dIn;
    logic             forceEn;
    logic [1:0]       forceSel;
    logic             mReady;

    logic [2:0]       rdyRr, rdyFp;
    logic             mvRr, mvFp;
    logic [15:0]      mdRr, mdFp;
    logic [1:0]       msRr, msFp;
    logic [15:0]      cntRr, cntFp;

    int               errors = 0;
    int               checks = 0;
    logic [17:0]      sbq[$];
    vec_t             tbl[30];
    int               nRows;

    always #5 clk = ~clk;

    muxd_arb #(.N(3), .W(16), .RR(1'b1)) dutRr (
        .clk(clk), .rst_n(rst_n), .req_valid_in(vRr), .req_data_in(dIn),
        .req_ready_out(rdyRr), .force_en_in(forceEn), .force_sel_in(forceSel),
        .m_valid_out(mvRr), .m_data_out(mdRr), .m_sel_out(msRr),
        .m_ready_in(mReady), .xfer_cnt_out(cntRr)
    );

    muxd_arb #(.N(3), .W(16), .RR(1'b0)) dutFp (
        .clk(clk), .rst_n(rst_n), .req_valid_in(vFp), .req_data_in(dIn),
        .req_ready_out(rdyFp), .force_en_in(forceEn), .force_sel_in(forceSel),
        .m_valid_out(mvFp), .m_data_out(mdFp), .m_sel_out(msFp),
        .m_ready_in(mReady), .xfer_cnt_out(cntFp)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic fp, input logic [2:0] v, input logic mr,
                                 input logic fe, input logic [1:0] fs);
        vRr      = fp ? 3'b000 : v;
        vFp      = fp ? v : 3'b000;
        mReady   = mr;
        forceEn  = fe;
        forceSel = fs;
    endtask

    function automatic vec_t mk(input logic fp, input logic [2:0] v, input logic mr,
                                input logic fe, input logic [1:0] fs, input logic [2:0] er,
                                input logic em, input logic [15:0] ed, input logic [1:0] es);
        vec_t r;
        r.fp = fp; r.valid = v; r.mready = mr; r.fen = fe; r.fsel = fs;
        r.expRdy = er; r.expMv = em; r.expData = ed; r.expSel = es;
        return r;
    endfunction

    // One cycle: ready is checked before the edge, registered outputs one step after it.
    task automatic runRow(input vec_t r, input string tag);
        logic [2:0]  aRdy;
        logic        aMv;
        logic [15:0] aData;
        logic [1:0]  aSel;
        logic [17:0] expWord;
        int          idx;
        applyStimulus(r.fp, r.valid, r.mready, r.fen, r.fsel);
        #1;
        aRdy  = r.fp ? rdyFp : rdyRr;
        aMv   = r.fp ? mvFp  : mvRr;
        aData = r.fp ? mdFp  : mdRr;
        aSel  = r.fp ? msFp  : msRr;
        checkOutput($sformatf("%s_rdy", tag), 32'(aRdy), 32'(r.expRdy));
        if (aMv && r.mready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s_sb: got word 0x%0h, expected none queued", tag, {aSel, aData});
            end else begin
                expWord = sbq.pop_front();
                checkOutput($sformatf("%s_sb", tag), 32'({aSel, aData}), 32'(expWord));
            end
        end
        if (r.expRdy != 3'b000) begin
            idx = r.expRdy[0] ? 0 : (r.expRdy[1] ? 1 : 2);
            sbq.push_back({2'(idx), dIn[idx]});
        end
        @(posedge clk);
        #1;
        aMv   = r.fp ? mvFp : mvRr;
        aData = r.fp ? mdFp : mdRr;
        aSel  = r.fp ? msFp : msRr;
        checkOutput($sformatf("%s_mv", tag),   32'(aMv),   32'(r.expMv));
        checkOutput($sformatf("%s_data", tag), 32'(aData), 32'(r.expData));
        checkOutput($sformatf("%s_sel", tag),  32'(aSel),  32'(r.expSel));
    endtask

    initial begin
        rst_n = 1'b0;
        dIn[0] = 16'h1111; dIn[1] = 16'h2222; dIn[2] = 16'h3333;
        vRr = 3'b111; vFp = 3'b111; mReady = 1'b1; forceEn = 1'b0; forceSel = 2'd0;

        #2;
        checkOutput("rst_rdy_rr", 32'(rdyRr), 32'h0);
        checkOutput("rst_rdy_fp", 32'(rdyFp), 32'h0);
        checkOutput("rst_mv",     32'(mvRr),  32'h0);
        checkOutput("rst_data",   32'(mdRr),  32'h0);
        checkOutput("rst_sel",    32'(msRr),  32'h0);
        checkOutput("rst_cnt",    32'(cntRr), 32'h0);
        @(posedge clk);
        #2;
        checkOutput("rst_edge_mv",  32'(mvRr),  32'h0);
        checkOutput("rst_edge_cnt", 32'(cntRr), 32'h0);
        vFp = 3'b000;
        #5;
        rst_n = 1'b1;

        nRows = 0;
        tbl[nRows++] = mk(0, 3'b111, 1, 0, 0, 3'b001, 1, 16'h1111, 0);
        tbl[nRows++] = mk(0, 3'b111, 1, 0, 0, 3'b010, 1, 16'h2222, 1);
        tbl[nRows++] = mk(0, 3'b111, 1, 0, 0, 3'b100, 1, 16'h3333, 2);
        tbl[nRows++] = mk(0, 3'b111, 1, 0, 0, 3'b001, 1, 16'h1111, 0);
        tbl[nRows++] = mk(0, 3'b000, 1, 0, 0, 3'b000, 0, 16'h1111, 0);
        tbl[nRows++] = mk(0, 3'b101, 1, 0, 0, 3'b100, 1, 16'h3333, 2);
        tbl[nRows++] = mk(0, 3'b101, 1, 0, 0, 3'b001, 1, 16'h1111, 0);
        tbl[nRows++] = mk(0, 3'b111, 1, 1, 2, 3'b100, 1, 16'h3333, 2);
        tbl[nRows++] = mk(0, 3'b111, 1, 1, 2, 3'b100, 1, 16'h3333, 2);
        tbl[nRows++] = mk(0, 3'b111, 1, 0, 0, 3'b001, 1, 16'h1111, 0);
        tbl[nRows++] = mk(0, 3'b111, 1, 1, 3, 3'b000, 0, 16'h1111, 0);
        tbl[nRows++] = mk(0, 3'b111, 1, 1, 3, 3'b000, 0, 16'h1111, 0);
        tbl[nRows++] = mk(0, 3'b111, 0, 1, 1, 3'b010, 1, 16'h2222, 1);
        tbl[nRows++] = mk(0, 3'b111, 0, 0, 0, 3'b000, 1, 16'h2222, 1);
        tbl[nRows++] = mk(0, 3'b111, 1, 0, 0, 3'b100, 1, 16'h3333, 2);
        tbl[nRows++] = mk(0, 3'b000, 1, 0, 0, 3'b000, 0, 16'h3333, 2);
        tbl[nRows++] = mk(1, 3'b110, 1, 0, 0, 3'b010, 1, 16'h2222, 1);
        tbl[nRows++] = mk(1, 3'b110, 1, 0, 0, 3'b010, 1, 16'h2222, 1);
        tbl[nRows++] = mk(1, 3'b110, 1, 0, 0, 3'b010, 1, 16'h2222, 1);
        tbl[nRows++] = mk(1, 3'b100, 1, 0, 0, 3'b100, 1, 16'h3333, 2);
        tbl[nRows++] = mk(1, 3'b111, 1, 0, 0, 3'b001, 1, 16'h1111, 0);
        tbl[nRows++] = mk(1, 3'b000, 1, 0, 0, 3'b000, 0, 16'h1111, 0);

        for (int i = 0; i < nRows; i++) begin
            runRow(tbl[i], $sformatf("row%0d", i));
        end
        checkOutput("tbl_cnt_rr", 32'(cntRr), 32'd11);
        checkOutput("tbl_cnt_fp", 32'(cntFp), 32'd5);
        checkOutput("tbl_sb_left", 32'(sbq.size()), 32'd0);

        // Backpressure: a held word must survive four stalled cycles, then hand over with no bubble.
        dIn[0] = 16'hBEEF;
        runRow(mk(0, 3'b001, 1, 0, 0, 3'b001, 1, 16'hBEEF, 0), "bp_load");
        dIn[1] = 16'hCAFE;
        for (int i = 0; i < 4; i++) begin
            runRow(mk(0, 3'b010, 0, 0, 0, 3'b000, 1, 16'hBEEF, 0), $sformatf("bp_stall%0d", i));
        end
        runRow(mk(0, 3'b010, 1, 0, 0, 3'b010, 1, 16'hCAFE, 1), "bp_resume");
        runRow(mk(0, 3'b000, 1, 0, 0, 3'b000, 0, 16'hCAFE, 1), "bp_drain");
        runRow(mk(0, 3'b100, 0, 0, 0, 3'b100, 1, 16'h3333, 2), "bp_full");
        checkOutput("bp_cnt", 32'(cntRr), 32'd14);

        #2;
        rst_n = 1'b0;
        #1;
        sbq.delete();
        checkOutput("arst_mv",   32'(mvRr),  32'h0);
        checkOutput("arst_data", 32'(mdRr),  32'h0);
        checkOutput("arst_cnt",  32'(cntRr), 32'h0);
        checkOutput("arst_rdy",  32'(rdyRr), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("arst_hold_mv", 32'(mvRr), 32'h0);

        dIn[0] = 16'h1111; dIn[1] = 16'h2222; dIn[2] = 16'h3333;
        applyStimulus(0, 3'b111, 1, 0, 0);
        #2;
        rst_n = 1'b1;
        repeat (65537) @(posedge clk);
        #1;
        checkOutput("wrap_cnt",  32'(cntRr), 32'h0001);
        checkOutput("wrap_mv",   32'(mvRr),  32'h1);
        checkOutput("wrap_sel",  32'(msRr),  32'd1);
        checkOutput("wrap_data", 32'(mdRr),  32'h2222);
        applyStimulus(0, 3'b000, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muxd_arb.md
# muxd_arb

Registered, arbitrated successor to the combinational `muxd` word selector for the 16-bit CPU datapath. It merges N valid/ready requester channels of W-bit data onto one output channel through a single output register stage. Arbitration is either round-robin or fixed-priority, with an optional forced-select mode. Typical use: sharing the register-file write port or the memory bus among the ALU, load unit and immediate path.

## Interface
- `N`, default 3: number of input channels, minimum 2.
- `W`, default 16: data width in bits.
- `RR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, lowest index wins.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req_valid_in`  input  [N-1:0]  channel i holds valid data.
- `req_data_in`  input  [N-1:0][W-1:0]  per-channel data.
- `req_ready_out`  output  [N-1:0]  channel i is accepted this cycle if its valid is also high; at most one bit is set.
- `force_en_in`  input  1  when 1, only channel `force_sel_in` is eligible.
- `force_sel_in`  input  [$clog2(N)-1:0]  forced channel index.
- `m_valid_out`  output  1  output register holds a word.
- `m_data_out`  output  [W-1:0]  registered word.
- `m_sel_out`  output  [$clog2(N)-1:0]  index of the channel that supplied `m_data_out`.
- `m_ready_in`  input  1  downstream consumes the word when this and `m_valid_out` are both high.
- `xfer_cnt_out`  output  16  count of accepted input transfers; wraps from 0xFFFF to 0.

## Operation
- Output stage has two states:
  - EMPTY (`m_valid_out`=0).
  - FULL (`m_valid_out`=1).
- `space` = !`m_valid_out` || `m_ready_in`. This is combinational and allows a drain and a load in the same cycle.
- Eligible set:
  - `force_en_in`=0: all channels with valid high.
  - `force_en_in`=1: only `req_valid_in[force_sel_in]`.
  - `force_sel_in` ≥ N: empty set, no grant.
- Grant selection, one-hot combinational, over the eligible set:
  - RR=1: the first eligible index at or above pointer `ptr`, searching upward and wrapping modulo N.
  - RR=0: the lowest eligible index.
- `req_ready_out[g]` = grant[g] && `space`. All other bits are 0.
  - `req_ready_out` may depend combinationally on `req_valid_in` and `m_ready_in`.
- Accept (valid && ready on channel g), registered on the next edge:
  - `m_data_out` ← `req_data_in[g]`.
  - `m_sel_out` ← g.
  - `m_valid_out` ← 1.
  - `xfer_cnt_out` += 1.
  - RR=1 only: `ptr` ← (g+1) mod N.
- Drain with no accept: `m_valid_out` ← 0. `m_data_out` and `m_sel_out` keep their last values.
- FULL with `m_ready_in`=0: all output registers hold, and all `req_ready_out` bits are 0 (backpressure).
- `ptr` changes only on an accept, including forced accepts. Idle cycles do not move it.
- Requesters must hold valid and data stable until accepted. The block does not check this.
- Reset values (`rst_n` low), applied immediately and asynchronously:
  - `m_valid_out`=0, `m_data_out`=0, `m_sel_out`=0.
  - `xfer_cnt_out`=0, `ptr`=0.
- Reset mid-transfer discards the held word. Nothing is accepted while `rst_n` is low.

## Timing
- Latency: 1 cycle from the accept edge to `m_valid_out`=1.
- Throughput: one word per cycle while `m_ready_in` stays high.
- Simultaneous drain and load: the new word replaces the old one in the same edge, with no bubble.
- `force_en_in` and `force_sel_in` are sampled combinationally in the accept cycle. Changing them while FULL and stalled has no effect on the held word.
- Reset deassertion: the first accept is possible on the first rising edge after `rst_n` goes high.
- N not a power of two: `ptr` wraps from N-1 to 0, never to an index ≥ N.

## Test plan
- Reset with N=3, RR=1:
  - All valids high, `rst_n` low → all `req_ready_out`=0, all outputs 0.
  - Release reset, `m_ready_in`=1, data 0x1111/0x2222/0x3333 → outputs 0x1111, 0x2222, 0x3333, 0x1111 on consecutive cycles; `m_sel_out` 0,1,2,0.
- Fixed priority, RR=0:
  - Channels 1 and 2 valid continuously → channel 1 wins every cycle; channel 2 is never granted.
  - Drop channel 1 → channel 2 is accepted on the next edge.
- Backpressure:
  - Accept 0xBEEF, then hold `m_ready_in`=0 for 4 cycles → `m_data_out` stays 0xBEEF, `req_ready_out`=0 throughout.
  - Raise `m_ready_in` → the next word follows with no bubble cycle.
- Forced select:
  - `force_en_in`=1, `force_sel_in`=2, all valid → only channel 2 is accepted and `ptr` becomes 0.
  - `force_sel_in`=3 with N=3 → no accept, `m_valid_out` falls to 0 after the drain.
- Counter wrap: 65537 back-to-back accepts → `xfer_cnt_out`=0x0001.
- Async reset mid-stream: assert `rst_n` low between clock edges while FULL → `m_valid_out`=0 immediately, without waiting for an edge.
